int_to_float: RTL and testbench

- Converts a 32-bit two's-complement signed integer into an IEEE-754 single-precision value.
- Rounding is round-to-nearest, ties-to-even.
- It sits directly upstream of the single-precision adder, so integer operands can be fed onto the adder's input_a/input_b streams.
- It uses the same strobe/acknowledge stream handshake on input and output, and is a multi-cycle state machine with one-bit-per-cycle normalisation.

---
 rtl/int_to_float_pkg.sv | 17 +
 rtl/int_to_float.sv | 147 ++++++++++++++
 tb/tb_int_to_float.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/int_to_float_pkg.sv
// Shared constants and state encoding for the integer/float conversion blocks.
package int_to_float_pkg;

  localparam logic [7:0]  FloatBias = 8'd127;
  localparam logic [31:0] FloatZero = 32'h0000_0000;

  typedef enum logic [3:0] {
    StGetA     = 4'd0,
    StConvert0 = 4'd1,
    StConvert1 = 4'd2,
    StConvert2 = 4'd3,
    StRound    = 4'd4,
    StPack     = 4'd5,
    StPutZ     = 4'd6
  } state_e;

endpackage

// File: rtl/int_to_float.sv
// Signed 32-bit integer to IEEE-754 single converter, round-to-nearest-even,
// with strobe/acknowledge streams and one-bit-per-cycle normalisation.
module int_to_float
  import int_to_float_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  state_e             state_q, state_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        value_q, value_d;
  logic [23:0]        z_m_q, z_m_d;
  logic signed [9:0]  z_e_q, z_e_d;
  logic               z_s_q, z_s_d;
  logic               guard_q, guard_d;
  logic               round_bit_q, round_bit_d;
  logic               sticky_q, sticky_d;
  logic [31:0]        z_q, z_d;
  logic               input_a_ack_q, input_a_ack_d;
  logic [31:0]        output_z_q, output_z_d;
  logic               output_z_stb_q, output_z_stb_d;

  always_comb begin
    state_d        = state_q;
    a_d            = a_q;
    value_d        = value_q;
    z_m_d          = z_m_q;
    z_e_d          = z_e_q;
    z_s_d          = z_s_q;
    guard_d        = guard_q;
    round_bit_d    = round_bit_q;
    sticky_d       = sticky_q;
    z_d            = z_q;
    input_a_ack_d  = input_a_ack_q;
    output_z_d     = output_z_q;
    output_z_stb_d = output_z_stb_q;

    case (state_q)
      StGetA: begin
        input_a_ack_d = 1'b1;
        if (input_a_ack_q && input_a_stb) begin
          a_d           = input_a;
          input_a_ack_d = 1'b0;
          state_d       = StConvert0;
        end
      end
      StConvert0: begin
        if (a_q == 32'd0) begin
          z_s_d   = 1'b0;
          z_e_d   = -10'sd127;
          z_m_d   = 24'd0;
          state_d = StPack;
        end else begin
          z_s_d   = a_q[31];
          // -2^31 negates to itself, which is the right unsigned magnitude.
          value_d = a_q[31] ? (~a_q + 32'd1) : a_q;
          z_e_d   = 10'sd31;
          state_d = StConvert1;
        end
      end
      StConvert1: begin
        if (!value_q[31]) begin
          value_d = value_q << 1;
          z_e_d   = z_e_q - 10'sd1;
        end else begin
          state_d = StConvert2;
        end
      end
      StConvert2: begin
        z_m_d       = value_q[31:8];
        guard_d     = value_q[7];
        round_bit_d = value_q[6];
        sticky_d    = |value_q[5:0];
        state_d     = StRound;
      end
      StRound: begin
        if (guard_q && (round_bit_q || sticky_q || z_m_q[0])) begin
          z_m_d = z_m_q + 24'd1;
          // Mantissa wraps to zero; bumping the exponent keeps the value exact.
          if (z_m_q == 24'hFF_FFFF) begin
            z_e_d = z_e_q + 10'sd1;
          end
        end
        state_d = StPack;
      end
      StPack: begin
        z_d     = {z_s_q, z_e_q[7:0] + FloatBias, z_m_q[22:0]};
        state_d = StPutZ;
      end
      StPutZ: begin
        output_z_stb_d = 1'b1;
        output_z_d     = z_q;
        if (output_z_stb_q && output_z_ack) begin
          output_z_stb_d = 1'b0;
          state_d        = StGetA;
        end
      end
      default: begin
        state_d = StGetA;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StGetA;
      a_q            <= 32'd0;
      value_q        <= 32'd0;
      z_m_q          <= 24'd0;
      z_e_q          <= 10'sd0;
      z_s_q          <= 1'b0;
      guard_q        <= 1'b0;
      round_bit_q    <= 1'b0;
      sticky_q       <= 1'b0;
      z_q            <= FloatZero;
      input_a_ack_q  <= 1'b0;
      output_z_q     <= FloatZero;
      output_z_stb_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      value_q        <= value_d;
      z_m_q          <= z_m_d;
      z_e_q          <= z_e_d;
      z_s_q          <= z_s_d;
      guard_q        <= guard_d;
      round_bit_q    <= round_bit_d;
      sticky_q       <= sticky_d;
      z_q            <= z_d;
      input_a_ack_q  <= input_a_ack_d;
      output_z_q     <= output_z_d;
      output_z_stb_q <= output_z_stb_d;
    end
  end

  assign input_a_ack  = input_a_ack_q;
  assign output_z     = output_z_q;
  assign output_z_stb = output_z_stb_q;

endmodule

// File: tb/tb_int_to_float.sv
// Directed bench for int_to_float: values, latency, handshake, back-pressure and reset.
module tb_int_to_float;

  logic        clk;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int checks;
  int errors;

  int_to_float dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits for input_a_ack, offers one operand and waits for the result strobe.
  // lat = edges from accept to output_z_stb high, or -1 on timeout.
  task automatic send(input logic [31:0] data, output logic [31:0] res, output int lat,
                      output logic ack_after_accept);
    int n;
    n = 0;
    lat = -1;
    res = 32'hDEAD_BEEF;
    ack_after_accept = 1'b1;
    while (!input_a_ack && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!input_a_ack) return;
    input_a     = data;
    input_a_stb = 1'b1;
    @(posedge clk); #1;
    input_a_stb      = 1'b0;
    ack_after_accept = input_a_ack;
    n = 0;
    while (!output_z_stb && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (output_z_stb) begin
      lat = n;
      res = output_z;
    end
  endtask

  task automatic pulse_ack();
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if (input_a_ack !== 1'b0) begin
      errors++; $display("FAIL reset_ack got %b want 0", input_a_ack);
    end
    checks++;
    if (output_z_stb !== 1'b0) begin
      errors++; $display("FAIL reset_stb got %b want 0", output_z_stb);
    end
    checks++;
    if (output_z !== 32'h0) begin
      errors++; $display("FAIL reset_z got %h want 00000000", output_z);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (input_a_ack !== 1'b1) begin
      errors++; $display("FAIL reset_first_ack got %b want 1", input_a_ack);
    end
  endtask

  task automatic test_zero();
    logic [31:0] r;
    int l;
    logic a;
    send(32'd0, r, l, a);
    checks++;
    if (a !== 1'b0) begin
      errors++; $display("FAIL zero_ack_drop got %b want 0", a);
    end
    checks++;
    if (r !== 32'h0000_0000) begin
      errors++; $display("FAIL zero_value got %h want 00000000", r);
    end
    checks++;
    if (l != 3) begin
      errors++; $display("FAIL zero_latency got %0d want 3", l);
    end
    checks++;
    if (input_a_ack !== 1'b0) begin
      errors++; $display("FAIL zero_ack_with_stb got %b want 0", input_a_ack);
    end
    pulse_ack();
  endtask

  task automatic test_values();
    logic [31:0] vin  [9];
    logic [31:0] vexp [9];
    int          vlat [9];
    logic [31:0] r;
    int l;
    logic a;
    vin[0] = 32'd1;          vexp[0] = 32'h3F80_0000; vlat[0] = 37;
    vin[1] = 32'hFFFF_FFFF;  vexp[1] = 32'hBF80_0000; vlat[1] = 37;
    vin[2] = 32'h8000_0000;  vexp[2] = 32'hCF00_0000; vlat[2] = 6;
    vin[3] = 32'h7FFF_FFFF;  vexp[3] = 32'h4F00_0000; vlat[3] = 7;
    vin[4] = 32'd16777217;   vexp[4] = 32'h4B80_0000; vlat[4] = 13;
    vin[5] = 32'd16777219;   vexp[5] = 32'h4B80_0002; vlat[5] = 13;
    vin[6] = -32'sd16777219; vexp[6] = 32'hCB80_0002; vlat[6] = 13;
    vin[7] = 32'd100;        vexp[7] = 32'h42C8_0000; vlat[7] = 31;
    vin[8] = 32'd5;          vexp[8] = 32'h40A0_0000; vlat[8] = 35;
    for (int i = 0; i < 9; i++) begin
      send(vin[i], r, l, a);
      checks++;
      if (r !== vexp[i]) begin
        errors++; $display("FAIL value[%0d] in %h got %h want %h", i, vin[i], r, vexp[i]);
      end
      checks++;
      if (l != vlat[i]) begin
        errors++; $display("FAIL latency[%0d] in %h got %0d want %0d", i, vin[i], l, vlat[i]);
      end
      pulse_ack();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    int l;
    logic a;
    int bad;
    send(32'd100, r, l, a);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (output_z_stb !== 1'b1 || output_z !== 32'h42C8_0000 || input_a_ack !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_hold got %0d bad cycles want 0 (z %h)", bad, output_z);
    end
    pulse_ack();
    checks++;
    if (output_z_stb !== 1'b0) begin
      errors++; $display("FAIL bp_stb_fall got %b want 0", output_z_stb);
    end
    checks++;
    if (output_z !== 32'h42C8_0000) begin
      errors++; $display("FAIL bp_z_hold got %h want 42c80000", output_z);
    end
    send(-32'sd1, r, l, a);
    checks++;
    if (r !== 32'hBF80_0000) begin
      errors++; $display("FAIL bp_next got %h want bf800000", r);
    end
    pulse_ack();
  endtask

  task automatic test_early_ack();
    logic [31:0] r;
    int l;
    logic a;
    output_z_ack = 1'b1;
    send(32'd16777219, r, l, a);
    checks++;
    if (r !== 32'h4B80_0002 || l != 13) begin
      errors++; $display("FAIL early_ack got %h lat %0d want 4b800002 lat 13", r, l);
    end
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    checks++;
    if (output_z_stb !== 1'b0) begin
      errors++; $display("FAIL early_ack_fall got %b want 0", output_z_stb);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int l;
    logic a;
    int n;
    n = 0;
    while (!input_a_ack && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    input_a     = 32'd5;
    input_a_stb = 1'b1;
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (input_a_ack !== 1'b0 || output_z_stb !== 1'b0 || output_z !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset got ack %b stb %b z %h want 0 0 00000000",
               input_a_ack, output_z_stb, output_z);
    end
    @(negedge clk);
    rst = 1'b1;
    send(32'd5, r, l, a);
    checks++;
    if (r !== 32'h40A0_0000) begin
      errors++; $display("FAIL mid_reset_after got %h want 40a00000", r);
    end
    checks++;
    if (l != 35) begin
      errors++; $display("FAIL mid_reset_latency got %0d want 35", l);
    end
    pulse_ack();
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    input_a      = 32'd0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;
    test_reset();
    test_zero();
    test_values();
    test_backpressure();
    test_early_ack();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
